// File: rtl/bus_master_if_pkg.sv
// Shared bus constants and the bus master FSM state encoding.
package bus_master_if_pkg;

    localparam int BUS_WORD_ADDR_W = 30;
    localparam int BUS_WORD_DATA_W = 32;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        BUS_MASTER_IF_IDLE   = 2'd0,
        BUS_MASTER_IF_REQ    = 2'd1,
        BUS_MASTER_IF_ACCESS = 2'd2,
        BUS_MASTER_IF_STALL  = 2'd3
    } bmif_state_e;

endpackage

// File: rtl/bus_master_if_timer.sv
// Saturating access-timeout counter: clears while idle, counts enabled cycles,
// flags expiry in the cycle whose increment would reach LIMIT.
module bus_master_if_timer #(
    parameter int LIMIT = 255,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic reset_,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign expire_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/bus_master_if.sv
// Bus master interface: turns a one-cycle CPU access into the req/grant/strobe/ready
// handshake. Define BUS_MASTER_IF_TIMEOUT_EN to abort stuck accesses with busErr.
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int WORD_ADDR_W = BUS_WORD_ADDR_W,
    parameter int WORD_DATA_W = BUS_WORD_DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic                   as_,
    input  logic                   rw,
    input  logic [WORD_DATA_W-1:0] wrData,
    output logic [WORD_DATA_W-1:0] rdData,
    output logic                   busy,
    output logic                   busErr,
    output logic                   busReq_,
    input  logic                   busGrnt_,
    output logic [WORD_ADDR_W-1:0] busAddr,
    output logic                   busAs_,
    output logic                   busRW,
    output logic [WORD_DATA_W-1:0] busWrData,
    input  logic [WORD_DATA_W-1:0] busRdData,
    input  logic                   busRdy_
);

    bmif_state_e            state_q, state_d;
    logic                   busReq_q, busReq_d;
    logic                   busAs_q, busAs_d;
    logic                   busRW_q, busRW_d;
    logic                   busErr_q, busErr_d;
    logic [WORD_ADDR_W-1:0] busAddr_q, busAddr_d;
    logic [WORD_DATA_W-1:0] busWrData_q, busWrData_d;
    logic [WORD_DATA_W-1:0] rdBuf_q, rdBuf_d;
    logic                   tmo_expire;

`ifdef BUS_MASTER_IF_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    bus_master_if_timer #(
        .LIMIT (TIMEOUT_CYC),
        .CNT_W (TMO_W)
    ) u_timer (
        .clk      (clk),
        .reset_   (reset_),
        .clr_i    (state_q != BUS_MASTER_IF_ACCESS),
        .en_i     ((state_q == BUS_MASTER_IF_ACCESS) && busRdy_),
        .expire_o (tmo_expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign tmo_expire     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= BUS_MASTER_IF_IDLE;
            busReq_q    <= DISABLE_;
            busAs_q     <= DISABLE_;
            busRW_q     <= READ;
            busErr_q    <= 1'b0;
            busAddr_q   <= '0;
            busWrData_q <= '0;
            rdBuf_q     <= '0;
        end else begin
            state_q     <= state_d;
            busReq_q    <= busReq_d;
            busAs_q     <= busAs_d;
            busRW_q     <= busRW_d;
            busErr_q    <= busErr_d;
            busAddr_q   <= busAddr_d;
            busWrData_q <= busWrData_d;
            rdBuf_q     <= rdBuf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_MASTER_IF_IDLE:
                if (!as_ && !flush) state_d = BUS_MASTER_IF_REQ;
            BUS_MASTER_IF_REQ:
                if (flush)          state_d = BUS_MASTER_IF_IDLE;
                else if (!busGrnt_) state_d = BUS_MASTER_IF_ACCESS;
            // flush is deliberately ignored here: an issued access must complete
            BUS_MASTER_IF_ACCESS:
                if (!busRdy_)        state_d = stall ? BUS_MASTER_IF_STALL : BUS_MASTER_IF_IDLE;
                else if (tmo_expire) state_d = BUS_MASTER_IF_IDLE;
            BUS_MASTER_IF_STALL:
                if (!stall) state_d = BUS_MASTER_IF_IDLE;
            default: state_d = BUS_MASTER_IF_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        rdData      = rdBuf_q;
        busReq_d    = busReq_q;
        busAs_d     = busAs_q;
        busRW_d     = busRW_q;
        busErr_d    = 1'b0;
        busAddr_d   = busAddr_q;
        busWrData_d = busWrData_q;
        rdBuf_d     = rdBuf_q;
        case (state_q)
            BUS_MASTER_IF_IDLE:
                if (!as_ && !flush) begin
                    busy        = 1'b1;
                    busAddr_d   = addr;
                    busRW_d     = rw;
                    busWrData_d = wrData;
                    busReq_d    = ENABLE_;
                end
            BUS_MASTER_IF_REQ: begin
                busy = 1'b1;
                if (flush)          busReq_d = DISABLE_;
                else if (!busGrnt_) busAs_d  = ENABLE_;
            end
            BUS_MASTER_IF_ACCESS: begin
                busy    = busRdy_;
                busAs_d = DISABLE_;
                if (!busRdy_) begin
                    busReq_d = DISABLE_;
                    rdData   = busRdData;
                    if (busRW_q == READ) rdBuf_d = busRdData;
                end else if (tmo_expire) begin
                    busReq_d = DISABLE_;
                    busErr_d = 1'b1;
                    busy     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign busReq_   = busReq_q;
    assign busAs_    = busAs_q;
    assign busRW     = busRW_q;
    assign busErr    = busErr_q;
    assign busAddr   = busAddr_q;
    assign busWrData = busWrData_q;

endmodule
